// File: rtl/pipe_elastic_chain_if.sv
// Handshake bundle for pipe_elastic_chain.
//   slave  : the chain side (consumes i_*, drives o_*).
//   master : the producer/consumer environment side.
// Signals:
//   i_valid/i_data/i_halt_tag -> producer offer, o_ready <- chain accepts
//   o_valid/o_data            -> output stage token, i_ready <- consumer accepts
//   i_flush_mask              -> per-stage empty request
//   o_count/o_halt            -> occupancy and sticky halt status
interface pipe_elastic_chain_if #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_STAGES = 4,
  parameter int unsigned NB_CNT    = 4
);
  logic                 i_valid;
  logic [NB_DATA-1:0]   i_data;
  logic                 i_halt_tag;
  logic                 o_ready;
  logic                 o_valid;
  logic [NB_DATA-1:0]   o_data;
  logic                 i_ready;
  logic [NB_STAGES-1:0] i_flush_mask;
  logic [NB_CNT-1:0]    o_count;
  logic                 o_halt;

  modport master (
    output i_valid, i_data, i_halt_tag, i_ready, i_flush_mask,
    input  o_ready, o_valid, o_data, o_count, o_halt
  );

  modport slave (
    input  i_valid, i_data, i_halt_tag, i_ready, i_flush_mask,
    output o_ready, o_valid, o_data, o_count, o_halt
  );
endinterface

// File: rtl/pipe_elastic_chain.sv
// N-stage elastic pipeline with valid/ready at both ends, single-cycle bubble
// collapsing, per-stage flush, debug clock-enable and a sticky halt raised when
// a halt-tagged token leaves the output stage.
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_dunit_clk_en debug clock enable; 0 freezes every register
//   chain_io       handshake bundle (slave modport), see pipe_elastic_chain_if
module pipe_elastic_chain #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_STAGES = 4,
  parameter int unsigned NB_CNT    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_dunit_clk_en,
  pipe_elastic_chain_if.slave        chain_io
);

  localparam int unsigned L = NB_STAGES - 1;

  logic [NB_STAGES-1:0]              v_q, v_d;
  logic [NB_STAGES-1:0]              h_q, h_d;
  logic [NB_STAGES-1:0][NB_DATA-1:0] d_q, d_d;
  logic                              halted_q, halted_d;
  logic [NB_CNT-1:0]                 cnt_q, cnt_d;

  logic                              en;
  logic                              ready;
  logic                              accept;
  logic [NB_STAGES-1:0]              adv;
  logic [NB_CNT-1:0]                 flushed;

  // Ready chain, evaluated from the output side so a stage can move into a
  // slot that is being vacated in the same cycle.
  always_comb begin
    en     = i_dunit_clk_en & ~halted_q;
    adv    = '0;
    adv[L] = v_q[L] & chain_io.i_ready & en;
    for (int s = int'(L) - 1; s >= 0; s--) begin
      adv[s] = v_q[s] & (~v_q[s+1] | adv[s+1]) & en;
    end
    ready  = en & (~v_q[0] | adv[0]);
    accept = chain_io.i_valid & ready;
  end

  always_comb begin
    v_d      = v_q;
    h_d      = h_q;
    d_d      = d_q;
    halted_d = halted_q;
    flushed  = '0;

    if (accept) begin
      v_d[0] = 1'b1;
      d_d[0] = chain_io.i_data;
      h_d[0] = chain_io.i_halt_tag;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end

    for (int s = 1; s < int'(NB_STAGES); s++) begin
      if (adv[s-1]) begin
        v_d[s] = 1'b1;
        d_d[s] = d_q[s-1];
        h_d[s] = h_q[s-1];
      end else if (adv[s]) begin
        v_d[s] = 1'b0;
      end
    end

    // Flush acts on the post-move contents: a token leaving a masked stage
    // survives downstream, while anything landing in a masked stage is lost.
    for (int s = 0; s < int'(NB_STAGES); s++) begin
      if (en && chain_io.i_flush_mask[s]) begin
        if (v_d[s]) flushed = flushed + NB_CNT'(1);
        v_d[s] = 1'b0;
        d_d[s] = '0;
        h_d[s] = 1'b0;
      end
    end

    if (adv[L] && h_q[L]) halted_d = 1'b1;

    cnt_d = cnt_q + NB_CNT'(accept) - NB_CNT'(adv[L]) - flushed;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      v_q      <= '0;
      h_q      <= '0;
      d_q      <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      v_q      <= v_d;
      h_q      <= h_d;
      d_q      <= d_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign chain_io.o_ready = ready;
  assign chain_io.o_valid = v_q[L] & en;
  assign chain_io.o_data  = d_q[L];
  assign chain_io.o_count = cnt_q;
  assign chain_io.o_halt  = halted_q;

endmodule

// File: tb/tb_pipe_elastic_chain.sv
module tb_pipe_elastic_chain;
  localparam int unsigned NB_DATA   = 32;
  localparam int unsigned NB_STAGES = 4;
  localparam int unsigned NB_CNT    = 4;
  localparam int          L         = NB_STAGES - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic dunit_en = 1'b1;

  always #5 clk = ~clk;

  pipe_elastic_chain_if #(.NB_DATA(NB_DATA), .NB_STAGES(NB_STAGES), .NB_CNT(NB_CNT)) bus ();

  pipe_elastic_chain #(.NB_DATA(NB_DATA), .NB_STAGES(NB_STAGES), .NB_CNT(NB_CNT)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_dunit_clk_en (dunit_en),
    .chain_io       (bus)
  );

  // Reference model: the chain is an ordered list of tokens (oldest first),
  // each knowing which slot it sits in.
  typedef struct {
    int                 pos;
    logic [NB_DATA-1:0] d;
    logic               h;
  } tok_t;

  tok_t q[$];
  int   np[$];
  bit   m_halted;
  bit   m_acc;
  int   compared;
  int   mismatched;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_en();
    return dunit_en && !m_halted;
  endfunction

  // Where each token will be after the coming edge. A token steps forward
  // when the slot ahead is free once the tokens in front have moved.
  task automatic plan(output bit rdy);
    int  prev;
    int  p;
    int  n;
    bit  e;
    e    = m_en();
    prev = L + 1;
    np.delete();
    foreach (q[i]) begin
      p = q[i].pos;
      n = p;
      if (e) begin
        if (i == 0 && p == L) n = bus.i_ready ? L + 1 : L;
        else if (p + 1 < prev) n = p + 1;
      end
      np.push_back(n);
      prev = n;
    end
    rdy = e && (q.size() == 0 || np[np.size()-1] != 0);
  endtask

  task automatic check_outputs();
    bit rdy;
    bit has_l;
    plan(rdy);
    has_l = q.size() > 0 && q[0].pos == L;
    chk("o_ready", bus.o_ready, rdy);
    chk("o_valid", bus.o_valid, has_l && m_en());
    if (has_l) chk("o_data", bus.o_data, q[0].d);
    chk("o_count", bus.o_count, q.size());
    chk("o_halt", bus.o_halt, m_halted);
  endtask

  task automatic advance_model();
    bit   rdy;
    bit   e;
    tok_t t;
    tok_t nq[$];
    e = m_en();
    plan(rdy);
    foreach (q[i]) begin
      if (np[i] <= L) begin
        t = q[i];
        t.pos = np[i];
        nq.push_back(t);
      end else if (q[i].h) begin
        m_halted = 1'b1;
      end
    end
    m_acc = bus.i_valid && rdy;
    if (m_acc) begin
      t.pos = 0;
      t.d   = bus.i_data;
      t.h   = bus.i_halt_tag;
      nq.push_back(t);
    end
    q.delete();
    foreach (nq[i]) if (!(e && bus.i_flush_mask[nq[i].pos])) q.push_back(nq[i]);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic drive(bit v, logic [NB_DATA-1:0] d, bit h, bit r, logic [NB_STAGES-1:0] m);
    bus.i_valid      = v;
    bus.i_data       = d;
    bus.i_halt_tag   = h;
    bus.i_ready      = r;
    bus.i_flush_mask = m;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_halted = 1'b0;
    m_acc    = 1'b0;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_count", bus.o_count, 0);
    chk("rst_o_halt", bus.o_halt, 0);
    chk("rst_o_ready", bus.o_ready, dunit_en);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill4(logic [NB_DATA-1:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, base + NB_DATA'(i), 1'b0, 1'b0, '0);
      cycle();
    end
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, '0);
      cycle();
    end
  endtask

  initial begin
    int                 peak;
    bit                 v;
    bit                 h;
    logic [NB_DATA-1:0] d;
    logic [NB_DATA-1:0] seq;

    compared   = 0;
    mismatched = 0;
    m_halted   = 1'b0;
    m_acc      = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    do_reset();

    // Short stream with the consumer always ready.
    peak = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 3) drive(1'b1, NB_DATA'(32'h11 * (i + 1)), 1'b0, 1'b1, '0);
      else       drive(1'b0, '0, 1'b0, 1'b1, '0);
      cycle();
      if (int'(bus.o_count) > peak) peak = int'(bus.o_count);
    end
    chk("stream_peak", peak, 3);

    // Fill with back-pressure, then one simultaneous in/out transfer.
    fill4(32'hB0);
    drive(1'b1, 32'hB4, 1'b0, 1'b0, '0);
    cycle();
    chk("full_count", bus.o_count, 4);
    chk("full_ready", bus.o_ready, 0);
    drive(1'b1, 32'hB4, 1'b0, 1'b1, '0);
    cycle();
    chk("swap_count", bus.o_count, 4);
    drain(6);

    // Leave tokens in stages 0 and 2, then watch the bubble collapse.
    fill4(32'hC0);
    drive(1'b0, '0, 1'b0, 1'b0, 4'b1010);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    cycle();
    chk("bubble_count", bus.o_count, 2);
    drain(6);

    // Flush the two input-side stages of a full chain.
    fill4(32'hD0);
    drive(1'b0, '0, 1'b0, 1'b0, 4'b0011);
    cycle();
    chk("flush_count", bus.o_count, 2);
    chk("flush_data", bus.o_data, 32'hD0);
    drain(6);

    // Halt-tagged token retires and freezes the chain.
    drive(1'b1, 32'hA0, 1'b0, 1'b1, '0); cycle();
    drive(1'b1, 32'hA1, 1'b1, 1'b1, '0); cycle();
    drive(1'b1, 32'hA2, 1'b0, 1'b1, '0); cycle();
    drain(8);
    chk("halt_o_halt", bus.o_halt, 1);
    chk("halt_o_valid", bus.o_valid, 0);
    chk("halt_o_ready", bus.o_ready, 0);
    chk("halt_frozen", bus.o_data, 32'hA2);
    do_reset();
    chk("post_rst_count", bus.o_count, 0);

    // Debug clock-enable dropped mid-stream.
    seq = 32'hE0;
    for (int i = 0; i < 20; i++) begin
      dunit_en = !(i >= 5 && i < 10);
      drive(i < 12, seq, 1'b0, 1'b1, '0);
      cycle();
      if (i >= 5 && i < 10) begin
        chk("dbg_o_valid", bus.o_valid, 0);
        chk("dbg_o_ready", bus.o_ready, 0);
      end
      if (m_acc) seq = seq + 1;
    end
    dunit_en = 1'b1;
    drain(6);

    // Randomized traffic; producer holds an offer until it is taken.
    v = 1'b0;
    h = 1'b0;
    d = '0;
    for (int n = 0; n < 600; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
        v = 1'b0;
        continue;
      end
      if (!(v && !m_acc)) begin
        v = $urandom_range(0, 2) != 0;
        d = $urandom;
        h = $urandom_range(0, 15) == 0;
      end
      dunit_en = $urandom_range(0, 9) != 0;
      drive(v, d, h, $urandom_range(0, 9) < 7,
            ($urandom_range(0, 7) == 0) ? NB_STAGES'($urandom) : '0);
      m_acc = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_chain.md
Name: pipe_elastic_chain

Overview:
- Parametrised successor to the fixed 5-stage IF/ID/EX/M/WB register chain.
- An N-stage elastic pipeline of data registers, each carrying valid and halt-tag bits.
- Provides valid/ready handshake at both ends, bubble collapsing, per-stage flush via mask, a global debug clock-enable (single-step), and a sticky halt raised when a halt-tagged token retires.
- Sits between an instruction/data producer and consumer. It replaces the hand-wired stall/flush/write-enable plumbing of the per-stage registers.

Parameters:
- NB_DATA, 32, payload width per stage.
- NB_STAGES, 4, number of register stages; legal range 2..8.
- NB_CNT, 4, occupancy counter width; must satisfy 2^NB_CNT > NB_STAGES.

Ports:
- i_clk, input, 1, clock; all state changes on the rising edge.
- i_reset, input, 1, asynchronous, active-low reset.
- i_dunit_clk_en, input, 1, debug-unit clock enable; 0 freezes all state.
- i_valid, input, 1, producer offers a token.
- i_data, input, NB_DATA, producer payload.
- i_halt_tag, input, 1, marks the offered token as a halt instruction.
- o_ready, output, 1, chain accepts the token this cycle.
- o_valid, output, 1, output stage holds a token.
- o_data, output, NB_DATA, payload of the output stage.
- i_ready, input, 1, consumer accepts the token.
- i_flush_mask, input, NB_STAGES, bit s=1 empties stage s at the edge.
- o_count, output, NB_CNT, number of valid stages.
- o_halt, output, 1, sticky; a halt-tagged token has retired.

Behaviour:
- **Reset** (i_reset=0, asynchronous):
  - all v[s]=0, d[s]=0, h[s]=0, halted=0.
  - Outputs: o_valid=0, o_data=0, o_count=0, o_halt=0.
  - o_ready=i_dunit_clk_en.
  - Reset mid-transfer discards every token; no partial state survives.
- **Stage indexing:** stage 0 is the input side; stage L=NB_STAGES-1 drives o_valid/o_data.
- **Enable:** en = i_dunit_clk_en & !halted.
- **Advance terms:**
  - adv[L] = v[L] & i_ready & en.
  - adv[s] = v[s] & (!v[s+1] | adv[s+1]) & en, for s<L. This is a combinational ready chain; bubbles collapse in one cycle.
- **Ports:**
  - o_ready = en & (!v[0] | adv[0]).
  - o_valid = v[L] & en.
  - o_data = d[L]; it is valid only while o_valid=1.
- **Load rules at the edge:**
  - Stage 0 loads {1, i_data, i_halt_tag} when i_valid & o_ready.
  - Otherwise, if adv[0], stage 0 becomes empty.
  - Stage s>0 loads from s-1 when adv[s-1]; otherwise it empties if adv[s]; otherwise it holds.
  - When en=0, nothing changes.
- **Latency and throughput:**
  - Empty chain: a token accepted at edge k appears at o_valid after edge k+L (L+1 registers deep).
  - Throughput is 1 token/cycle with continuous i_ready.
- **Flush:**
  - i_flush_mask[s]=1 forces v[s]=0, d[s]=0, h[s]=0 at the edge, overriding any load into s.
  - A token leaving s in the same cycle continues into s+1 unless s+1 is also masked.
  - An output transfer (o_valid & i_ready) completes even if mask[L]=1.
  - Flush is ignored while en=0.
- **Halt:**
  - An output transfer with h[L]=1 sets halted=1 at that edge; o_halt=1 from the next cycle.
  - Once halted: o_ready=0 and o_valid=0; contents stay frozen for debug inspection; flush is ignored.
  - Only reset clears halted.
- **Count:**
  - o_count is a registered counter: +1 on input accept, −1 on output transfer, −(number of valid stages cleared by flush).
  - Simultaneous events are summed in one edge.
  - It must always equal popcount(v); the bench asserts this every cycle.
  - It never exceeds NB_STAGES.
- **Full chain with i_ready=0:** o_ready=0; the producer must hold i_valid/i_data stable.
- **Simultaneous full-chain accept and output transfer:** allowed; the chain stays full and o_count is unchanged.

Test Plan:
- Default parameters; reset; stream 0x11,0x22,0x33 with i_ready=1 → 0x11 is at o_valid on the 4th cycle after acceptance; tokens emerge in order, one per cycle; o_count peaks at 3.
- Fill 4 tokens with i_ready=0 → o_ready=0, o_count=4. Raise i_ready for 1 cycle with i_valid=1 → 1 out, 1 in, o_count stays 4.
- Tokens in stages 0 and 2, stage 1 empty, i_ready=0 → next edge the stage 0 token collapses into stage 1; o_count=2.
- Full chain, i_flush_mask=4'b0011, i_ready=0 → o_count=2; stages 2,3 hold original data; o_data unchanged.
- Stream 0xA0, 0xA1 (halt_tag=1), 0xA2 → 0xA1 retires, then o_halt=1, o_valid=0, o_ready=0; 0xA2 remains frozen; an async reset pulse clears all.
- i_dunit_clk_en=0 mid-stream for 5 cycles → no state change, o_valid=0, o_ready=0; on re-enable the stream resumes with no loss or duplicate.
